pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  - Detects load-use hazards, EX-stage redirects, data-memory wait and halt.
//  - Drives per-register enable/flush, runs halt drain, keeps saturating perf counters.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for a 5-stage pipeline. It detects load-use hazards,
//   EX-stage redirects, data-memory wait and halt. It drives the PC and
//   pipeline-register enables and flushes, runs the halt drain, and keeps
//   saturating performance counters.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   id_rs1/id_rs2           source registers of the instruction in ID
//   id_use_rs1/id_use_rs2   ID instruction actually reads rs1/rs2
//   ex_mem_read, ex_rd      load flag and destination held in ID/EX
//   ex_redirect             taken branch / jump resolved in EX
//   ex_halt                 halt instruction sitting in ID/EX
//   dmem_req, dmem_ready    MEM-stage access pending / completing this cycle
//   pc_en, ifid_en, idex_en, exmem_en            load enables
//   ifid_flush, idex_flush, memwb_flush          bubble inserts
//   halted                  pipeline stopped (reset is the only exit)
//   mem_timeout             sticky: dmem wait exceeded MEM_TIMEOUT
//   stall_cnt, flush_cnt    saturating load-use stall / redirect counters
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W  = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRN_W-1:0]  DRAIN_INIT = DRN_W'(DRAIN_CYCLES);

  state_t             state_reg, state_next;
  state_t             ret_state_reg, ret_state_next;
  state_t             act_state;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [DRN_W-1:0]   drain_cnt_reg, drain_cnt_next;
  logic               timeout_reg, timeout_next;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;
  logic               stall_inc, flush_inc;
  logic               memstall, ldhaz;

  assign memstall = dmem_req & ~dmem_ready;
  assign ldhaz    = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    wait_cnt_next  = wait_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    timeout_next   = timeout_reg;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    act_state      = state_reg;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    ifid_flush     = 1'b0;
    idex_en        = 1'b1;
    idex_flush     = 1'b0;
    exmem_en       = 1'b1;
    memwb_flush    = 1'b0;
    halted         = 1'b0;

    if (state_reg == HALTED) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      halted      = 1'b1;
    end else if (memstall) begin
      // Freeze everything upstream of MEM; WB receives bubbles meanwhile.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      if (state_reg == MEM_WAIT) begin
        if (wait_cnt_reg == WAIT_MAX) begin
          timeout_next = 1'b1;
          state_next   = HALTED;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end else begin
        ret_state_next = state_reg;
        wait_cnt_next  = WAIT_W'(1);
        state_next     = MEM_WAIT;
      end
    end else begin
      // On release the cycle behaves exactly like the state we froze in,
      // so events held during the freeze are acted upon (and counted) now.
      act_state     = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;
      state_next    = act_state;
      wait_cnt_next = '0;
      if (act_state == DRAIN) begin
        // Front end already emptied by the halt; only EX/MEM and MEM/WB retire.
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (drain_cnt_reg <= DRN_W'(1)) begin
          drain_cnt_next = '0;
          state_next     = HALTED;
        end else begin
          drain_cnt_next = drain_cnt_reg - DRN_W'(1);
        end
      end else if (ex_halt) begin
        pc_en          = 1'b0;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
        drain_cnt_next = DRAIN_INIT;
        state_next     = DRAIN;
      end else if (ex_redirect) begin
        // PC loads the branch target; the wrong-path instructions are dropped.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (ldhaz) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end

    // Held in reset: keep every register closed and inject bubbles.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      ret_state_reg <= RUN;
      wait_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
      wait_cnt_reg  <= wait_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      timeout_reg   <= timeout_next;
      if (stall_inc && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_inc && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign mem_timeout = timeout_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;

endmodule
